cu_fsm: RTL

- Registered multicycle control-unit state machine for the RV32I core: state register, next-state decode and memory-wait handshake in one block.
- Generalises the combinational next-state table with these additions:
  - I-type ALU and LUI paths.
  - Stalls on `mem_ready` in memory states.
  - Memory-timeout and illegal-opcode trap.
  - Retired-instruction counter.
- Sits between the instruction register (opcode source) and the datapath/memory control decoder (consumes `state`).

---
 rtl/cu_pkg.sv | 44 ++++
 rtl/cu_next_state.sv | 82 ++++++++
 rtl/cu_fsm.sv | 123 ++++++++++++
 3 files changed

// File: rtl/cu_pkg.sv
// Shared constants for the RV32I multicycle control unit: state encoding,
// major opcodes and trap-cause codes, plus a small state-class helper.
package cu_pkg;

  // Fixed state encoding consumed by the datapath/memory control decoder
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXEC_R   = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_JUMP     = 4'd9;
  localparam logic [3:0] S_JAL_PC   = 4'd10;
  localparam logic [3:0] S_AUIPC    = 4'd11;
  localparam logic [3:0] S_JALR_PC  = 4'd12;
  localparam logic [3:0] S_EXEC_I   = 4'd13;
  localparam logic [3:0] S_LUI_WB   = 4'd14;
  localparam logic [3:0] S_TRAP     = 4'd15;

  // RV32I major opcodes
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  // Trap causes
  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

  // States that drive a memory request and may stall on mem_ready
  function automatic logic is_mem_state(input logic [3:0] s);
    return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
  endfunction

endpackage

// File: rtl/cu_next_state.sv
// Combinational next-state decode for the control unit. Flags illegal
// opcodes so the register block can record the trap cause.
module cu_next_state
  import cu_pkg::*;
#(
  parameter int OP_W = 7
) (
  input  logic [3:0]      state_i,
  input  logic [OP_W-1:0] op_i,
  input  logic            mem_ready_i,
  input  logic            timeout_hit_i,
  output logic [3:0]      ns_o,
  output logic            illegal_o
);

  // Next-state table; memory states stall on mem_ready or trap on timeout
  always_comb begin
    ns_o      = S_TRAP;
    illegal_o = 1'b0;
    case (state_i)
      S_FETCH: begin
        if (mem_ready_i)        ns_o = S_DECODE;
        else if (timeout_hit_i) ns_o = S_TRAP;
        else                    ns_o = S_FETCH;
      end
      S_DECODE: begin
        if ((op_i == OP_W'(OPC_LOAD)) || (op_i == OP_W'(OPC_STORE))) ns_o = S_MEMADR;
        else if (op_i == OP_W'(OPC_OP))                             ns_o = S_EXEC_R;
        else if (op_i == OP_W'(OPC_OP_IMM))                         ns_o = S_EXEC_I;
        else if (op_i == OP_W'(OPC_BRANCH))                         ns_o = S_BRANCH;
        else if ((op_i == OP_W'(OPC_JAL)) || (op_i == OP_W'(OPC_JALR))) ns_o = S_JUMP;
        else if (op_i == OP_W'(OPC_AUIPC))                          ns_o = S_AUIPC;
        else if (op_i == OP_W'(OPC_LUI))                            ns_o = S_LUI_WB;
        else begin
          ns_o      = S_TRAP;
          illegal_o = 1'b1;
        end
      end
      S_MEMADR: begin
        if (op_i == OP_W'(OPC_LOAD))       ns_o = S_MEMREAD;
        else if (op_i == OP_W'(OPC_STORE)) ns_o = S_MEMWRITE;
        else begin
          ns_o      = S_TRAP;
          illegal_o = 1'b1;
        end
      end
      S_MEMREAD: begin
        if (mem_ready_i)        ns_o = S_MEMWB;
        else if (timeout_hit_i) ns_o = S_TRAP;
        else                    ns_o = S_MEMREAD;
      end
      S_MEMWRITE: begin
        if (mem_ready_i)        ns_o = S_FETCH;
        else if (timeout_hit_i) ns_o = S_TRAP;
        else                    ns_o = S_MEMWRITE;
      end
      S_JUMP: begin
        if (op_i == OP_W'(OPC_JAL))       ns_o = S_JAL_PC;
        else if (op_i == OP_W'(OPC_JALR)) ns_o = S_JALR_PC;
        else begin
          ns_o      = S_TRAP;
          illegal_o = 1'b1;
        end
      end
      S_EXEC_R:  ns_o = S_ALUWB;
      S_EXEC_I:  ns_o = S_ALUWB;
      S_AUIPC:   ns_o = S_ALUWB;
      S_MEMWB:   ns_o = S_FETCH;
      S_ALUWB:   ns_o = S_FETCH;
      S_BRANCH:  ns_o = S_FETCH;
      S_JAL_PC:  ns_o = S_FETCH;
      S_JALR_PC: ns_o = S_FETCH;
      S_LUI_WB:  ns_o = S_FETCH;
      S_TRAP:    ns_o = S_TRAP;
      default: begin
        ns_o      = S_TRAP;
        illegal_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/cu_fsm.sv
// Registered multicycle control unit for the RV32I core. Holds the state
// register, memory-wait counter, retired-instruction counter and trap cause.
module cu_fsm
  import cu_pkg::*;
#(
  parameter int STATE_W     = 4,
  parameter int OP_W        = 7,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    op,
  input  logic               mem_ready,
  output logic [STATE_W-1:0] state,
  output logic               mem_req,
  output logic               mem_we,
  output logic               ir_write,
  output logic               instr_done,
  output logic               trap,
  output logic [1:0]         trap_cause,
  output logic [CNT_W-1:0]   instret
);

  // Counter only needs to reach MEM_TIMEOUT-1; with timeout disabled it saturates
  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT =
    (MEM_TIMEOUT == 0) ? {WAIT_W{1'b0}} : WAIT_W'(MEM_TIMEOUT - 1);

  logic [3:0]        state_q;
  logic [3:0]        state_d;
  logic [WAIT_W-1:0] wait_q;
  logic [WAIT_W-1:0] wait_d;
  logic [CNT_W-1:0]  instret_q;
  logic [1:0]        cause_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic              trap_q;
  logic              illegal_s;
  logic              timeout_hit_s;
  logic              in_wait_s;
  logic              instr_done_s;

  assign in_wait_s = is_mem_state(state_q);

  cu_next_state #(
    .OP_W(OP_W)
  ) u_next_state (
    .state_i       (state_q),
    .op_i          (op),
    .mem_ready_i   (mem_ready),
    .timeout_hit_i (timeout_hit_s),
    .ns_o          (state_d),
    .illegal_o     (illegal_s)
  );

  // Timeout fires on the last tolerated wait cycle unless memory answers
  always_comb begin
    timeout_hit_s = 1'b0;
    if ((MEM_TIMEOUT != 0) && in_wait_s && !mem_ready && (wait_q == WAIT_LIMIT)) begin
      timeout_hit_s = 1'b1;
    end else begin
      timeout_hit_s = 1'b0;
    end
  end

  // Wait counter restarts on any state change or completed access
  always_comb begin
    wait_d = {WAIT_W{1'b0}};
    if ((state_d != state_q) || mem_ready || !in_wait_s) begin
      wait_d = {WAIT_W{1'b0}};
    end else if (wait_q != {WAIT_W{1'b1}}) begin
      wait_d = wait_q + WAIT_W'(1);
    end else begin
      wait_d = wait_q;
    end
  end

  // Retire whenever an instruction's last state hands back to FETCH
  always_comb begin
    instr_done_s = 1'b0;
    if ((state_d == S_FETCH) && (state_q != S_FETCH) && (state_q != S_TRAP)) begin
      instr_done_s = 1'b1;
    end else begin
      instr_done_s = 1'b0;
    end
  end

  // State, counters, trap cause and registered Moore outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      wait_q    <= {WAIT_W{1'b0}};
      instret_q <= {CNT_W{1'b0}};
      cause_q   <= CAUSE_NONE;
      mem_req_q <= 1'b1;
      mem_we_q  <= 1'b0;
      trap_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (instr_done_s) begin
        instret_q <= instret_q + CNT_W'(1);
      end
      if ((state_q != S_TRAP) && (state_d == S_TRAP)) begin
        cause_q <= illegal_s ? CAUSE_ILLEGAL : CAUSE_TIMEOUT;
      end
      mem_req_q <= is_mem_state(state_d);
      mem_we_q  <= (state_d == S_MEMWRITE);
      trap_q    <= (state_d == S_TRAP);
    end
  end

  assign state      = STATE_W'(state_q);
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign trap       = trap_q;
  assign trap_cause = cause_q;
  assign instret    = instret_q;
  assign ir_write   = (state_q == S_FETCH) && mem_ready;
  assign instr_done = instr_done_s;

endmodule
